rv32i_insn_encoder: RTL and testbench

//  Inverse of instruction decode: packs RV32I fields (opcode/funct/regs/imm) into 32-bit words and

---
 rtl/rv32i_insn_encoder_if.sv | 36 +++
 rtl/rv32i_insn_encoder.sv | 136 +++++++++++++
 tb/tb_rv32i_insn_encoder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_insn_encoder_if.sv
// Field-set input and instruction-memory write bus of the RV32I encoder.
// The master drives field sets and start.
// The slave (the encoder) drives ready, the memory write strobe and its status.
interface rv32i_insn_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output start, in_valid, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err, err_code
  );

  modport slave (
    input  start, in_valid, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, err, err_code
  );
endinterface

// File: rtl/rv32i_insn_encoder.sv
// RV32I instruction encoder / program loader.
// Packs field sets into 32-bit instruction words and writes them to consecutive word addresses.
// Checks immediates for range and alignment, and stops in ERROR on the first bad set.
module rv32i_insn_encoder #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input logic                 clk,
  input logic                 rst,
  rv32i_insn_encoder_if.slave bus
);

  // Controller states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  // Error codes reported on err_code.
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OPCODE   = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_MISALIGN = 2'b11;

  // RV32I major opcodes.
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Count value held just before the final accepted word.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MAX_WORDS - 1);

  logic [1:0]        state;
  logic [ADDR_W:0]   count_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [1:0]        err_code_q;

  logic              ready;
  logic              accept;
  logic signed [31:0] imm_s;
  logic [31:0]       imm;
  logic [31:0]       enc_word;
  logic [1:0]        enc_code;

  assign imm   = bus.in_imm;
  assign imm_s = $signed(bus.in_imm);

  // A field set is taken only while running, and start always pre-empts it.
  assign ready  = (state == ST_RUN) && !bus.start;
  assign accept = bus.in_valid && ready;

  // Pack the presented field set and classify it. Misalignment outranks range errors.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    enc_word = '0;
    enc_code = ERR_NONE;
    case (bus.in_opcode)
      OP_R: begin
        enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      end
      OP_LOAD, OP_IMM, OP_JALR: begin
        enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        if (imm_s < -32'sd2048 || imm_s > 32'sd2047) enc_code = ERR_RANGE;
      end
      OP_STORE: begin
        enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
        if (imm_s < -32'sd2048 || imm_s > 32'sd2047) enc_code = ERR_RANGE;
      end
      OP_BRANCH: begin
        enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    imm[4:1], imm[11], bus.in_opcode};
        if (imm[0])                                       enc_code = ERR_MISALIGN;
        else if (imm_s < -32'sd4096 || imm_s > 32'sd4094) enc_code = ERR_RANGE;
      end
      OP_LUI, OP_AUIPC: begin
        enc_word = {imm[31:12], bus.in_rd, bus.in_opcode};
        if (imm[11:0] != 12'd0) enc_code = ERR_MISALIGN;
      end
      OP_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
        if (imm[0])                                                 enc_code = ERR_MISALIGN;
        else if (imm_s < -32'sd1048576 || imm_s > 32'sd1048574)     enc_code = ERR_RANGE;
      end
      default: enc_code = ERR_OPCODE;
    endcase
  end

  // Controller, write pointer and the one-cycle registered write port.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_code_q  <= ERR_NONE;
    end else begin
      mem_we_q <= 1'b0;
      if (bus.start) begin
        state      <= ST_RUN;
        count_q    <= '0;
        err_code_q <= ERR_NONE;
      end else if (accept) begin
        if (enc_code != ERR_NONE) begin
          state      <= ST_ERROR;
          err_code_q <= enc_code;
        end else begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= count_q[ADDR_W-1:0];
          mem_wdata_q <= enc_word;
          count_q     <= count_q + 1'b1;
          if (count_q == LAST_IDX) state <= ST_FULL;
        end
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.count     = count_q;
  assign bus.full      = (state == ST_FULL);
  assign bus.err       = (state == ST_ERROR);
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_rv32i_insn_encoder.sv
// Self-checking bench for rv32i_insn_encoder.
// Runs directed vectors, immediate boundary cases, and random traffic.
// All results are compared against a behavioural reference model.
module tb_rv32i_insn_encoder;
  localparam int ADDR_W = 10;
  localparam int MAXW   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_insn_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  rv32i_insn_encoder #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int {M_IDLE, M_RUN, M_FULL, M_ERROR} mstate_t;

  int n_vec  = 0;
  int n_miss = 0;

  mstate_t     m_state;
  int          m_count;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_code;

  logic [6:0] ops [9] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder, written directly from the instruction-format rules.
  function automatic void model_encode(
    input  logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
    input  logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
    input  logic [31:0] imm, output logic [31:0] w, output logic [1:0] code);
    longint v;
    v    = longint'($signed(imm));
    w    = '0;
    code = 2'b00;
    case (op)
      7'h33: w = {f7, rs2, rs1, f3, rd, op};
      7'h03, 7'h13, 7'h67: begin
        w = {imm[11:0], rs1, f3, rd, op};
        if (v < -2048 || v > 2047) code = 2'b10;
      end
      7'h23: begin
        w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        if (v < -2048 || v > 2047) code = 2'b10;
      end
      7'h63: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        if (v % 2 != 0)                code = 2'b11;
        else if (v < -4096 || v > 4094) code = 2'b10;
      end
      7'h37, 7'h17: begin
        w = {imm[31:12], rd, op};
        if (imm % 4096 != 0) code = 2'b11;
      end
      7'h6F: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        if (v % 2 != 0)                              code = 2'b11;
        else if (v < -(64'sd1 <<< 20) || v > (64'sd1 <<< 20) - 2) code = 2'b10;
      end
      default: code = 2'b01;
    endcase
  endfunction

  // One clock: check ready, advance the model with the driven inputs, then check outputs after the edge.
  task automatic tick();
    logic        exp_ready;
    logic [31:0] w;
    logic [1:0]  code;
    #1;
    exp_ready = (m_state == M_RUN) && !bus.start;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    if (rst) begin
      m_state = M_IDLE; m_count = 0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_code = 2'b00;
    end else begin
      m_we = 1'b0;
      if (bus.start) begin
        m_state = M_RUN; m_count = 0; m_code = 2'b00;
      end else if (bus.in_valid && exp_ready) begin
        model_encode(bus.in_opcode, bus.in_funct3, bus.in_funct7, bus.in_rd,
                     bus.in_rs1, bus.in_rs2, bus.in_imm, w, code);
        if (code != 2'b00) begin
          m_state = M_ERROR; m_code = code;
        end else begin
          m_we = 1'b1; m_addr = 32'(m_count); m_wdata = w;
          m_count++;
          if (m_count == MAXW) m_state = M_FULL;
        end
      end
    end
    @(posedge clk);
    #1;
    check("mem_we",    32'(bus.mem_we),   32'(m_we));
    check("mem_addr",  32'(bus.mem_addr), m_addr);
    check("mem_wdata", bus.mem_wdata,     m_wdata);
    check("count",     32'(bus.count),    32'(m_count));
    check("full",      32'(bus.full),     32'(m_state == M_FULL));
    check("err",       32'(bus.err),      32'(m_state == M_ERROR));
    check("err_code",  32'(bus.err_code), 32'(m_code));
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm);
    bus.in_opcode = op;  bus.in_funct3 = f3; bus.in_funct7 = f7;
    bus.in_rd     = rd;  bus.in_rs1    = rs1; bus.in_rs2   = rs2;
    bus.in_imm    = imm;
  endtask

  task automatic do_start();
    bus.start = 1'b1; bus.in_valid = 1'b0;
    tick();
    bus.start = 1'b0;
  endtask

  // Start fresh, present a single set and compare the reported code with a hand-derived value.
  task automatic err_case(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] imm, input logic [1:0] exp_code);
    do_start();
    set_fields(op, f3, 7'd0, 5'd1, 5'd2, 5'd3, imm);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check(tag, 32'(bus.err_code), 32'(exp_code));
    check({tag, "_we"}, 32'(bus.mem_we), 32'(exp_code == 2'b00));
  endtask

  initial begin
    int r;
    logic [31:0] u;
    rst = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b0;
    set_fields(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    m_state = M_IDLE; m_count = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_code = 2'b00;

    @(posedge clk);
    tick();
    rst = 1'b0;

    // IDLE ignores a held set; start in the same cycle as in_valid also ignores it.
    set_fields(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    bus.in_valid = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_vs_valid_count", 32'(bus.count), 32'd0);

    // addi x1,x0,5
    tick();
    check("addi_word", bus.mem_wdata, 32'h00500093);
    check("addi_addr", 32'(bus.mem_addr), 32'd0);
    // add x3,x1,x2 then sw x2,8(x1) back-to-back
    set_fields(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    check("add_word", bus.mem_wdata, 32'h002081B3);
    set_fields(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    check("sw_word", bus.mem_wdata, 32'h0020A423);
    check("sw_addr", 32'(bus.mem_addr), 32'd2);
    check("sw_count", 32'(bus.count), 32'd3);
    // beq x1,x2,-8 fills the memory
    set_fields(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8);
    tick();
    check("beq_word", bus.mem_wdata, 32'hFE208CE3);
    check("full_flag", 32'(bus.full), 32'd1);
    check("full_count", 32'(bus.count), 32'd4);
    tick();
    tick();
    check("full_no_write", 32'(bus.mem_we), 32'd0);

    // Restart: next write lands at address 0.
    bus.in_valid = 1'b0;
    do_start();
    set_fields(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    bus.in_valid = 1'b1;
    tick();
    check("jal_word", bus.mem_wdata, 32'h001000EF);
    check("jal_addr", 32'(bus.mem_addr), 32'd0);
    set_fields(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    tick();
    check("lui_word", bus.mem_wdata, 32'h123452B7);
    bus.in_valid = 1'b0;

    // Immediate boundaries and error priority.
    err_case("addi_2048",   7'h13, 3'd0, 32'd2048,       2'b10);
    tick();
    check("err_ready", 32'(bus.in_ready), 32'd0);
    err_case("addi_2047",   7'h13, 3'd0, 32'd2047,       2'b00);
    err_case("addi_m2048",  7'h13, 3'd0, -32'sd2048,     2'b00);
    err_case("addi_m2049",  7'h13, 3'd0, -32'sd2049,     2'b10);
    err_case("sw_2048",     7'h23, 3'd2, 32'd2048,       2'b10);
    err_case("sw_m2048",    7'h23, 3'd2, -32'sd2048,     2'b00);
    err_case("beq_6",       7'h63, 3'd0, 32'd6,          2'b00);
    err_case("beq_7",       7'h63, 3'd0, 32'd7,          2'b11);
    err_case("beq_4094",    7'h63, 3'd0, 32'd4094,       2'b00);
    err_case("beq_m4096",   7'h63, 3'd0, -32'sd4096,     2'b00);
    err_case("beq_4096",    7'h63, 3'd0, 32'd4096,       2'b10);
    err_case("beq_4097",    7'h63, 3'd0, 32'd4097,       2'b11);
    err_case("jal_max",     7'h6F, 3'd0, 32'd1048574,    2'b00);
    err_case("jal_over",    7'h6F, 3'd0, 32'd1048576,    2'b10);
    err_case("jal_min",     7'h6F, 3'd0, -32'sd1048576,  2'b00);
    err_case("jal_odd",     7'h6F, 3'd0, 32'd3,          2'b11);
    err_case("lui_low",     7'h37, 3'd0, 32'h00000123,   2'b11);
    err_case("bad_op",      7'h7F, 3'd0, 32'd4097,       2'b01);

    // Reset right after an accept drops the pending write.
    do_start();
    set_fields(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    bus.in_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("rst_drops_we", 32'(bus.mem_we), 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      rst = (r == 0);
      bus.start = (r < 4) || (m_state != M_RUN && r < 35);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      bus.in_opcode = (r < 9) ? ops[r] : 7'($urandom);
      bus.in_funct3 = 3'($urandom);
      bus.in_funct7 = 7'($urandom);
      bus.in_rd     = 5'($urandom);
      bus.in_rs1    = 5'($urandom);
      bus.in_rs2    = 5'($urandom);
      u = $urandom;
      case ($urandom_range(0, 3))
        0: bus.in_imm = u;
        1: bus.in_imm = 32'(int'($urandom_range(0, 8191)) - 4096);
        2: bus.in_imm = 32'(int'($urandom_range(0, 4095)) * 2 - 4096);
        default: begin
          u[11:0] = 12'd0;
          bus.in_imm = u;
        end
      endcase
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
